// File: rtl/sync_up_counter.sv
// Synchronous up-counter with terminal-count compare, clamped parallel load,
// wrap or saturate at MAX_COUNT, sticky overflow flag and cout/cin cascading.
module sync_up_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter bit SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cin,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             cout,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

    logic             advance;
    logic             ovf_event;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_next;
    logic             ovf_next;

    assign tc           = (count == MAX_VAL);
    assign cout         = tc & en & cin;
    assign advance      = en & cin;
    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    // load outranks advance, so a load cycle can never produce an overflow
    assign ovf_event    = advance & tc & ~load & ~clr;

    always_comb begin
        count_next = count;
        if (clr) begin
            count_next = '0;
        end else if (load) begin
            count_next = load_clamped;
        end else if (advance) begin
            if (tc) begin
                count_next = SATURATE ? MAX_VAL : '0;
            end else begin
                count_next = count + WIDTH'(1);
            end
        end
    end

    always_comb begin
        ovf_next = ovf;
        if (clr) begin
            ovf_next = 1'b0;
        end else if (ovf_event) begin
            ovf_next = 1'b1;
        end else if (ovf_clr) begin
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= count_next;
            ovf   <= ovf_next;
        end
    end

endmodule

// File: tb/tb_sync_up_counter.sv
// Bench for sync_up_counter: wrap, saturate/clamp and a two-stage cascade,
// each checked every cycle against an arithmetic model plus literal pins.
module tb_sync_up_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // wrap instance (defaults)
    logic       w_en = 0, w_cin = 1, w_clr = 0, w_load = 0, w_oc = 0;
    logic [3:0] w_lv = '0;
    logic [3:0] w_count;
    logic       w_tc, w_cout, w_ovf;

    // saturate instance (MAX_COUNT = 10)
    logic       s_en = 0, s_cin = 1, s_clr = 0, s_load = 0, s_oc = 0;
    logic [3:0] s_lv = '0;
    logic [3:0] s_count;
    logic       s_tc, s_cout, s_ovf;

    // cascade pair
    logic       c_en = 0, c_cin = 0;
    logic [3:0] lo_count, hi_count;
    logic       lo_tc, lo_cout, lo_ovf, hi_tc, hi_cout, hi_ovf;

    int  n_checks = 0;
    int  n_errors = 0;
    bit  chk_on   = 0;

    sync_up_counter u_wrap (
        .clk(clk), .rst(rst), .en(w_en), .cin(w_cin), .clr(w_clr), .load(w_load),
        .load_val(w_lv), .ovf_clr(w_oc), .count(w_count), .tc(w_tc), .cout(w_cout), .ovf(w_ovf)
    );

    sync_up_counter #(.WIDTH(4), .MAX_COUNT(10), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(s_en), .cin(s_cin), .clr(s_clr), .load(s_load),
        .load_val(s_lv), .ovf_clr(s_oc), .count(s_count), .tc(s_tc), .cout(s_cout), .ovf(s_ovf)
    );

    sync_up_counter u_lo (
        .clk(clk), .rst(rst), .en(c_en), .cin(c_cin), .clr(1'b0), .load(1'b0),
        .load_val(4'h0), .ovf_clr(1'b0), .count(lo_count), .tc(lo_tc), .cout(lo_cout), .ovf(lo_ovf)
    );

    sync_up_counter u_hi (
        .clk(clk), .rst(rst), .en(c_en), .cin(lo_cout), .clr(1'b0), .load(1'b0),
        .load_val(4'h0), .ovf_clr(1'b0), .count(hi_count), .tc(hi_tc), .cout(hi_cout), .ovf(hi_ovf)
    );

    // ---------------- behavioural model ----------------
    int m_w = 0, m_s = 0, m_c = 0;
    bit m_wo = 0, m_so = 0, m_lo_o = 0, m_hi_o = 0;

    function automatic void model_step(input int max, input bit sat, input bit en,
                                       input bit cin, input bit clr, input bit load,
                                       input int lv, input bit oc,
                                       inout int c, inout bit o);
        if (clr) begin
            c = 0;
            o = 0;
        end else if (load) begin
            c = (lv > max) ? max : lv;
            if (oc) o = 0;
        end else if (en && cin) begin
            if (c < max) begin
                c = c + 1;
                if (oc) o = 0;
            end else begin
                c = sat ? max : 0;
                o = 1;
            end
        end else if (oc) begin
            o = 0;
        end
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_w = 0; m_s = 0; m_c = 0;
            m_wo = 0; m_so = 0; m_lo_o = 0; m_hi_o = 0;
        end else begin
            model_step(15, 0, w_en, w_cin, w_clr, w_load, int'(w_lv), w_oc, m_w, m_wo);
            model_step(10, 1, s_en, s_cin, s_clr, s_load, int'(s_lv), s_oc, m_s, m_so);
            if (c_en && c_cin) begin
                if (m_c % 16 == 15) m_lo_o = 1;
                if (m_c == 255) m_hi_o = 1;
                m_c = (m_c + 1) % 256;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("w_count", int'(w_count), m_w);
            chk("w_flags", int'({w_tc, w_cout, w_ovf}),
                int'({m_w == 15, (m_w == 15) && w_en && w_cin, m_wo}));
            chk("s_count", int'(s_count), m_s);
            chk("s_flags", int'({s_tc, s_cout, s_ovf}),
                int'({m_s == 10, (m_s == 10) && s_en && s_cin, m_so}));
            chk("casc_val", int'({hi_count, lo_count}), m_c);
            chk("casc_flags", int'({lo_tc, lo_cout, lo_ovf, hi_tc, hi_cout, hi_ovf}),
                int'({m_c % 16 == 15, (m_c % 16 == 15) && c_en && c_cin, m_lo_o,
                      m_c / 16 == 15, (m_c == 255) && c_en && c_cin, m_hi_o}));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        #1 rst = 1'b0;
        #2;
        chk_on = 1;
        chk("reset_count", int'(w_count), 0);
        chk("reset_ovf_tc", int'({w_ovf, w_tc}), 0);
        tick(2);
        #3 rst = 1'b1;
        #1;

        // wrap: 17 advancing edges
        w_en = 1; w_cin = 1;
        tick(15);
        chk("wrap_at15", int'({w_count, w_tc, w_ovf}), int'({4'd15, 1'b1, 1'b0}));
        tick(1);
        chk("wrap_to0", int'({w_count, w_tc, w_ovf}), int'({4'd0, 1'b0, 1'b1}));
        tick(1);
        chk("wrap_to1", int'({w_count, w_ovf}), int'({4'd1, 1'b1}));

        // priority: clr beats load beats advance
        w_en = 0; w_load = 1; w_lv = 4'd5;
        tick(1);
        chk("prio_load5", int'(w_count), 5);
        w_clr = 1; w_load = 1; w_lv = 4'd9; w_en = 1;
        tick(1);
        chk("prio_clr", int'({w_count, w_ovf}), 0);
        w_clr = 0;
        tick(1);
        chk("prio_load9", int'(w_count), 9);
        w_load = 0; w_en = 0;

        // hold at 3
        w_load = 1; w_lv = 4'd3;
        tick(1);
        w_load = 0; w_en = 0; w_cin = 1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("hold_count", int'(w_count), 3);
            chk("hold_cout", int'(w_cout), 0);
        end

        // saturate and clamp
        s_load = 1; s_lv = 4'd14;
        tick(1);
        s_load = 0;
        chk("sat_clamp", int'({s_count, s_tc}), int'({4'd10, 1'b1}));
        s_en = 1; s_cin = 1;
        tick(3);
        chk("sat_hold", int'({s_count, s_ovf}), int'({4'd10, 1'b1}));
        s_oc = 1;
        tick(1);
        chk("sat_ovfclr_adv", int'(s_ovf), 1);
        s_en = 0;
        tick(1);
        chk("sat_ovfclr", int'(s_ovf), 0);
        s_oc = 0;

        // cascade
        c_en = 1; c_cin = 1;
        tick(15);
        chk("casc_0f", int'({hi_count, lo_count}), 8'h0F);
        tick(1);
        chk("casc_10", int'({hi_count, lo_count}), 8'h10);
        tick(15);
        chk("casc_1f", int'({hi_count, lo_count}), 8'h1F);
        c_cin = 0;
        tick(2);
        chk("casc_hold", int'({hi_count, lo_count}), 8'h1F);
        c_cin = 1;
        tick(1);
        chk("casc_20", int'({hi_count, lo_count}), 8'h20);
        c_en = 0;

        // asynchronous reset mid-count
        w_load = 1; w_lv = 4'd7;
        tick(1);
        w_load = 0;
        chk("arst_pre", int'(w_count), 7);
        w_en = 1; w_cin = 1;
        #2 rst = 1'b0;
        #1;
        chk("arst_immediate", int'({w_count, w_ovf}), 0);
        tick(1);
        chk("arst_ignored", int'(w_count), 0);
        #2 rst = 1'b1;
        tick(1);
        chk("arst_first_edge", int'(w_count), 1);
        w_en = 0;
        tick(2);

        chk_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
